// File: rtl/sprite_pkg.sv
// Shared constants and the sprite table entry type for the sprite compositor.
package sprite_pkg;

    localparam int RGB_W = 12;
    localparam int COL_W = 10;
    localparam int ROW_W = 9;
    localparam int DIM_W = 7;
    localparam int IDX_W = 4;

    localparam logic [RGB_W-1:0] KEY_DEFAULT = 12'h428;

    typedef struct packed {
        logic [COL_W-1:0] x;
        logic [ROW_W-1:0] y;
        logic [DIM_W-1:0] w;
        logic [DIM_W-1:0] h;
        logic             en;
    } spr_entry_t;

    // start <= pos < start+len, evaluated one bit wider so the end never wraps
    function automatic logic span_hit(input logic [COL_W-1:0] pos,
                                      input logic [COL_W-1:0] start,
                                      input logic [DIM_W-1:0] len);
        return (pos >= start) && ({1'b0, pos} < ({1'b0, start} + (COL_W+1)'(len)));
    endfunction

endpackage

// File: rtl/sprite_chan.sv
// One sprite channel: shadow/active table entry, hit test, ROM address stage
// and the hit delay line that lines the hit up with the returned ROM data.
module sprite_chan
    import sprite_pkg::*;
#(
    parameter int ADDR_W  = 14,
    parameter int ROM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  spr_entry_t        wr_entry,
    input  logic              frame_start,
    input  logic [COL_W-1:0]  col_addr,
    input  logic [ROW_W-1:0]  row_addr,
    output logic [ADDR_W-1:0] spr_addr,
    output logic              hit_aligned
);

    spr_entry_t       shadow;
    spr_entry_t       active;
    logic             hit;
    logic [ROM_LAT:0] hit_pipe;
    logic [ROW_W-1:0] row_off;
    logic [COL_W-1:0] col_off;

    always_comb begin
        hit     = active.en
                  && span_hit(col_addr, active.x, active.w)
                  && span_hit({1'b0, row_addr}, {1'b0, active.y}, active.h);
        row_off = row_addr - active.y;
        col_off = col_addr - active.x;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shadow   <= '0;
            active   <= '0;
            spr_addr <= '0;
            hit_pipe <= '0;
        end else begin
            if (wr_en) shadow <= wr_entry;
            if (frame_start) active <= shadow;
            spr_addr <= hit ? ADDR_W'(32'(row_off) * 32'(active.w) + 32'(col_off)) : '0;
            // hit_pipe[0] is stage 1; the tap at ROM_LAT meets spr_data
            hit_pipe <= {hit_pipe[ROM_LAT-1:0], hit};
        end
    end

    assign hit_aligned = hit_pipe[ROM_LAT];

endmodule

// File: rtl/sprite_compositor.sv
// Sprite compositor: per-sprite channels feed external ROMs; the final stage
// merges by priority over the background and tracks per-frame collisions.
module sprite_compositor
    import sprite_pkg::*;
#(
    parameter int               NUM_SPR = 8,
    parameter int               ADDR_W  = 14,
    parameter int               ROM_LAT = 1,
    parameter logic [RGB_W-1:0] KEY     = KEY_DEFAULT
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [COL_W-1:0]          col_addr,
    input  logic [ROW_W-1:0]          row_addr,
    input  logic                      pix_valid,
    input  logic                      frame_start,
    input  logic [RGB_W-1:0]          bg_pixel,
    input  logic                      cfg_valid,
    output logic                      cfg_ready,
    input  logic [IDX_W-1:0]          cfg_idx,
    input  logic [COL_W-1:0]          cfg_x,
    input  logic [ROW_W-1:0]          cfg_y,
    input  logic [DIM_W-1:0]          cfg_w,
    input  logic [DIM_W-1:0]          cfg_h,
    input  logic                      cfg_en,
    output logic [NUM_SPR*ADDR_W-1:0] spr_addr,
    input  logic [NUM_SPR*RGB_W-1:0]  spr_data,
    output logic [RGB_W-1:0]          pix_out,
    output logic                      pix_out_valid,
    output logic [NUM_SPR-1:0]        coll_flags
);

    logic               wr_accept;
    spr_entry_t         cfg_entry;
    logic [NUM_SPR-1:0] hit_d;
    logic [ROM_LAT:0]   vld_pipe;
    logic [RGB_W-1:0]   bg_pipe [ROM_LAT+1];
    logic [NUM_SPR-1:0] opaque;
    logic [NUM_SPR-1:0] coll_now;
    logic [NUM_SPR-1:0] sticky;
    logic [RGB_W-1:0]   merged;

    // Writes stall for the frame_start cycle so the shadow->active copy is clean
    assign cfg_ready = ~frame_start;
    assign wr_accept = cfg_valid & cfg_ready;
    assign cfg_entry = '{x: cfg_x, y: cfg_y, w: cfg_w, h: cfg_h, en: cfg_en};

    for (genvar i = 0; i < NUM_SPR; i++) begin : g_chan
        sprite_chan #(
            .ADDR_W  (ADDR_W),
            .ROM_LAT (ROM_LAT)
        ) u_chan (
            .clk         (clk),
            .rst         (rst),
            .wr_en       (wr_accept && (cfg_idx == IDX_W'(i))),
            .wr_entry    (cfg_entry),
            .frame_start (frame_start),
            .col_addr    (col_addr),
            .row_addr    (row_addr),
            .spr_addr    (spr_addr[i*ADDR_W +: ADDR_W]),
            .hit_aligned (hit_d[i])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe <= '0;
            for (int unsigned k = 0; k < ROM_LAT + 1; k++) bg_pipe[k] <= '0;
        end else begin
            vld_pipe   <= {vld_pipe[ROM_LAT-1:0], pix_valid};
            bg_pipe[0] <= bg_pixel;
            for (int unsigned k = 1; k < ROM_LAT + 1; k++) bg_pipe[k] <= bg_pipe[k-1];
        end
    end

    // Ascending scan: the last opaque sprite found (highest index) wins
    always_comb begin
        merged = bg_pipe[ROM_LAT];
        opaque = '0;
        for (int unsigned i = 0; i < NUM_SPR; i++) begin
            opaque[i] = hit_d[i] && (spr_data[i*RGB_W +: RGB_W] != KEY);
            if (opaque[i]) merged = spr_data[i*RGB_W +: RGB_W];
        end
        coll_now = (vld_pipe[ROM_LAT] && ($countones(opaque) > 1)) ? opaque : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pix_out       <= '0;
            pix_out_valid <= 1'b0;
            sticky        <= '0;
            coll_flags    <= '0;
        end else begin
            pix_out       <= vld_pipe[ROM_LAT] ? merged : '0;
            pix_out_valid <= vld_pipe[ROM_LAT];
            if (frame_start) begin
                coll_flags <= sticky;
                sticky     <= coll_now;
            end else begin
                sticky <= sticky | coll_now;
            end
        end
    end

endmodule

// File: tb/tb_sprite_compositor.sv
// Self-checking bench: directed scenarios plus random scan/config traffic,
// compared every cycle against a table-level behavioural model.
module tb_sprite_compositor;
    import sprite_pkg::*;

    localparam int NUM_SPR = 8;
    localparam int ADDR_W  = 14;
    localparam int ROM_LAT = 2;
    localparam int LAT     = ROM_LAT + 2;
    localparam logic [11:0] KEY = KEY_DEFAULT;

    logic                      clk = 1'b0;
    logic                      rst = 1'b1;
    logic [9:0]                col_addr = '0;
    logic [8:0]                row_addr = '0;
    logic                      pix_valid = 1'b0;
    logic                      frame_start = 1'b0;
    logic [11:0]               bg_pixel = '0;
    logic                      cfg_valid = 1'b0;
    logic                      cfg_ready;
    logic [3:0]                cfg_idx = '0;
    logic [9:0]                cfg_x = '0;
    logic [8:0]                cfg_y = '0;
    logic [6:0]                cfg_w = '0;
    logic [6:0]                cfg_h = '0;
    logic                      cfg_en = 1'b0;
    logic [NUM_SPR*ADDR_W-1:0] spr_addr;
    logic [NUM_SPR*12-1:0]     spr_data;
    logic [11:0]               pix_out;
    logic                      pix_out_valid;
    logic [NUM_SPR-1:0]        coll_flags;

    sprite_compositor #(
        .NUM_SPR (NUM_SPR),
        .ADDR_W  (ADDR_W),
        .ROM_LAT (ROM_LAT),
        .KEY     (KEY)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .col_addr      (col_addr),
        .row_addr      (row_addr),
        .pix_valid     (pix_valid),
        .frame_start   (frame_start),
        .bg_pixel      (bg_pixel),
        .cfg_valid     (cfg_valid),
        .cfg_ready     (cfg_ready),
        .cfg_idx       (cfg_idx),
        .cfg_x         (cfg_x),
        .cfg_y         (cfg_y),
        .cfg_w         (cfg_w),
        .cfg_h         (cfg_h),
        .cfg_en        (cfg_en),
        .spr_addr      (spr_addr),
        .spr_data      (spr_data),
        .pix_out       (pix_out),
        .pix_out_valid (pix_out_valid),
        .coll_flags    (coll_flags)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ROM contents: a pattern with frequent KEY words, or a per-sprite constant
    logic        rom_mode  [NUM_SPR];
    logic [11:0] rom_const [NUM_SPR];

    function automatic logic [11:0] rom_word(input int s, input int a);
        if (rom_mode[s]) return rom_const[s];
        if (a % 7 == 3) return KEY;
        return 12'((a * 37 + s * 291 + 5) & 32'hFFF);
    endfunction

    logic [11:0] rom_pipe [ROM_LAT][NUM_SPR];
    always @(posedge clk) begin
        for (int s = 0; s < NUM_SPR; s++) begin
            rom_pipe[0][s] <= rom_word(s, int'(spr_addr[s*ADDR_W +: ADDR_W]));
            for (int k = 1; k < ROM_LAT; k++) rom_pipe[k][s] <= rom_pipe[k-1][s];
        end
    end
    always_comb begin
        spr_data = '0;
        for (int s = 0; s < NUM_SPR; s++) spr_data[s*12 +: 12] = rom_pipe[ROM_LAT-1][s];
    end

    // Reference model state
    int s_x [NUM_SPR], s_y [NUM_SPR], s_w [NUM_SPR], s_h [NUM_SPR], s_en [NUM_SPR];
    int a_x [NUM_SPR], a_y [NUM_SPR], a_w [NUM_SPR], a_h [NUM_SPR], a_en [NUM_SPR];

    typedef struct {
        logic [11:0]        pix;
        logic               vld;
        logic [NUM_SPR-1:0] coll;
    } exp_t;
    exp_t exp_q[$];

    logic [NUM_SPR*ADDR_W-1:0] addr_exp = '0;
    logic [NUM_SPR-1:0]        m_sticky = '0;
    logic [NUM_SPR-1:0]        m_flags  = '0;
    logic                      prev_fs  = 1'b0;
    logic                      primed   = 1'b0;

    logic        d_rst = 1'b1, d_fs = 1'b0, d_cv = 1'b0, d_en = 1'b0, d_vld = 1'b0;
    logic [3:0]  d_ci = '0;
    logic [9:0]  d_x = '0, d_col = '0;
    logic [8:0]  d_y = '0, d_row = '0;
    logic [6:0]  d_w = '0, d_h = '0;
    logic [11:0] d_bg = '0;

    function automatic bit covers(input int s, input int c, input int r);
        return a_en[s] != 0 && c >= a_x[s] && c < a_x[s] + a_w[s]
                            && r >= a_y[s] && r < a_y[s] + a_h[s];
    endfunction

    function automatic int addr_of(input int s, input int c, input int r);
        return ((r - a_y[s]) * a_w[s] + (c - a_x[s])) % (1 << ADDR_W);
    endfunction

    // One clock: check outputs of the edge just passed, then drive and model the next cycle
    task automatic tick();
        exp_t e;
        logic [NUM_SPR-1:0] om;
        logic [11:0] pix;
        @(negedge clk);
        if (primed) begin
            check("spr_addr", spr_addr, addr_exp);
            e = exp_q.pop_front();
            check("pix_out_valid", pix_out_valid, e.vld);
            check("pix_out", pix_out, e.pix);
            if (prev_fs) begin
                m_flags  = m_sticky;
                m_sticky = e.coll;
            end else begin
                m_sticky = m_sticky | e.coll;
            end
            check("coll_flags", coll_flags, m_flags);
        end
        rst = d_rst; frame_start = d_fs; cfg_valid = d_cv; cfg_idx = d_ci;
        cfg_x = d_x; cfg_y = d_y; cfg_w = d_w; cfg_h = d_h; cfg_en = d_en;
        col_addr = d_col; row_addr = d_row; pix_valid = d_vld; bg_pixel = d_bg;
        #1;
        if (!d_rst) check("cfg_ready", cfg_ready, !d_fs);
        if (d_rst) begin
            for (int s = 0; s < NUM_SPR; s++) begin
                s_x[s] = 0; s_y[s] = 0; s_w[s] = 0; s_h[s] = 0; s_en[s] = 0;
                a_x[s] = 0; a_y[s] = 0; a_w[s] = 0; a_h[s] = 0; a_en[s] = 0;
            end
            m_sticky = '0; m_flags = '0; prev_fs = 1'b0; addr_exp = '0;
            exp_q.delete();
            e.pix = '0; e.vld = 1'b0; e.coll = '0;
            repeat (LAT) exp_q.push_back(e);
            primed = 1'b1;
        end else begin
            om = '0;
            pix = d_bg;
            for (int s = 0; s < NUM_SPR; s++) begin
                addr_exp[s*ADDR_W +: ADDR_W] =
                    covers(s, d_col, d_row) ? ADDR_W'(addr_of(s, d_col, d_row)) : '0;
                if (covers(s, d_col, d_row) && rom_word(s, addr_of(s, d_col, d_row)) != KEY)
                    om[s] = 1'b1;
            end
            for (int s = NUM_SPR - 1; s >= 0; s--) begin
                if (om[s]) begin
                    pix = rom_word(s, addr_of(s, d_col, d_row));
                    break;
                end
            end
            e.vld  = d_vld;
            e.pix  = d_vld ? pix : 12'h000;
            e.coll = (d_vld && $countones(om) >= 2) ? om : '0;
            exp_q.push_back(e);
            prev_fs = d_fs;
            if (d_fs) begin
                a_x = s_x; a_y = s_y; a_w = s_w; a_h = s_h; a_en = s_en;
            end else if (d_cv && d_ci < NUM_SPR) begin
                s_x[d_ci] = d_x; s_y[d_ci] = d_y; s_w[d_ci] = d_w;
                s_h[d_ci] = d_h; s_en[d_ci] = d_en;
            end
        end
    endtask

    task automatic do_reset();
        d_rst = 1'b1; d_fs = 1'b0; d_cv = 1'b0;
        tick();
        d_rst = 1'b0;
    endtask

    task automatic write_spr(input int idx, input int x, input int y, input int w,
                             input int h, input logic en);
        d_cv = 1'b1; d_ci = 4'(idx); d_x = 10'(x); d_y = 9'(y);
        d_w = 7'(w); d_h = 7'(h); d_en = en;
        tick();
        d_cv = 1'b0;
    endtask

    task automatic frame();
        d_fs = 1'b1;
        tick();
        d_fs = 1'b0;
    endtask

    task automatic pixel(input int c, input int r, input logic [11:0] bg);
        d_col = 10'(c); d_row = 9'(r); d_bg = bg; d_vld = 1'b1;
        tick();
        d_vld = 1'b0;
    endtask

    task automatic flush();
        repeat (LAT + 1) tick();
    endtask

    task automatic pixel_check(input string tag, input int c, input int r,
                               input logic [11:0] bg, input logic [11:0] exp);
        pixel(c, r, bg);
        repeat (LAT - 1) tick();
        @(posedge clk); #1;
        check(tag, pix_out, exp);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int s = 0; s < NUM_SPR; s++) begin
            rom_mode[s] = 1'b0; rom_const[s] = '0;
        end

        // Reset state
        do_reset();
        @(posedge clk); #1;
        check("rst_pix_out", pix_out, 12'h000);
        check("rst_pix_out_valid", pix_out_valid, 1'b0);
        check("rst_coll_flags", coll_flags, '0);
        check("rst_cfg_ready", cfg_ready, 1'b1);

        // Basic addressing and latency
        write_spr(0, 10, 20, 8, 8, 1'b1);
        frame();
        pixel(12, 22, 12'h123);
        @(posedge clk); #1;
        check("addr_12_22", spr_addr[ADDR_W-1:0], 18);
        repeat (LAT - 1) tick();
        @(posedge clk); #1;
        check("pix_12_22", pix_out, 12'h29F);
        flush();

        // Priority: higher index wins; KEY data is transparent
        rom_mode[0] = 1'b1; rom_const[0] = 12'hF00;
        rom_mode[1] = 1'b1; rom_const[1] = 12'h0F0;
        write_spr(0, 40, 40, 20, 20, 1'b1);
        write_spr(1, 45, 45, 20, 20, 1'b1);
        frame();
        pixel_check("prio_s1", 50, 50, 12'h00F, 12'h0F0);
        flush();
        rom_const[1] = KEY;
        pixel_check("s1_key", 50, 50, 12'h00F, 12'hF00);
        flush();

        // Collision from the first overlap shows up after the next frame_start
        frame();
        @(posedge clk); #1;
        check("coll_set", coll_flags, 8'b0000_0011);

        // Mid-frame shadow write is not visible until the next frame
        write_spr(0, 100, 40, 20, 20, 1'b1);
        pixel_check("old_x", 50, 50, 12'h0AB, 12'hF00);
        flush();
        frame();
        @(posedge clk); #1;
        check("coll_clear", coll_flags, 8'b0000_0000);
        pixel_check("new_x_bg", 50, 50, 12'h0AB, 12'h0AB);
        pixel_check("new_x_hit", 105, 50, 12'h0AB, 12'hF00);

        // Write in the cycle right after frame_start waits a whole frame
        frame();
        write_spr(0, 10, 40, 20, 20, 1'b1);
        pixel_check("fs1_write_old", 15, 45, 12'h0CD, 12'h0CD);
        frame();
        pixel_check("fs1_write_new", 15, 45, 12'h0CD, 12'hF00);

        // A write offered with frame_start stalls one cycle
        d_fs = 1'b1; d_cv = 1'b1; d_ci = 4'd3; d_x = 10'd300; d_y = 9'd300;
        d_w = 7'd4; d_h = 7'd4; d_en = 1'b1;
        tick();
        d_fs = 1'b0;
        tick();
        d_cv = 1'b0;
        flush();

        // Right edge: x+w past 1023 must not wrap to column 0
        rom_mode[0] = 1'b0; rom_mode[1] = 1'b0;
        write_spr(2, 1020, 0, 8, 4, 1'b1);
        frame();
        pixel(1023, 1, 12'h111);
        @(posedge clk); #1;
        check("edge_addr_1023", spr_addr[2*ADDR_W +: ADDR_W], 11);
        flush();
        pixel(0, 1, 12'h111);
        @(posedge clk); #1;
        check("no_wrap_col0", spr_addr[2*ADDR_W +: ADDR_W], 0);
        flush();

        // Reset during active scan with a collision in flight
        rom_mode[4] = 1'b1; rom_const[4] = 12'h111;
        rom_mode[5] = 1'b1; rom_const[5] = 12'h222;
        write_spr(4, 200, 200, 10, 10, 1'b1);
        write_spr(5, 205, 205, 10, 10, 1'b1);
        frame();
        d_vld = 1'b1;
        d_col = 10'd207; d_row = 9'd207; tick();
        d_col = 10'd208; d_row = 9'd208; tick();
        do_reset();
        for (int k = 0; k < LAT; k++) begin
            @(posedge clk); #1;
            check("post_rst_valid", pix_out_valid, 1'b0);
            tick();
        end
        d_vld = 1'b0;
        frame();
        @(posedge clk); #1;
        check("post_rst_flags", coll_flags, '0);
        flush();

        // Randomized traffic
        for (int s = 0; s < NUM_SPR; s++) rom_mode[s] = 1'b0;
        for (int f = 0; f < 8; f++) begin
            frame();
            for (int c = 0; c < 150; c++) begin
                d_cv  = ($urandom % 6) == 0;
                d_ci  = 4'($urandom % 16);
                d_x   = (($urandom % 4) == 0) ? 10'(990 + $urandom % 34) : 10'($urandom % 128);
                d_y   = 9'($urandom % 128);
                d_w   = 7'($urandom % 41);
                d_h   = 7'($urandom % 41);
                d_en  = ($urandom % 4) != 0;
                d_vld = ($urandom % 10) != 0;
                d_col = (($urandom % 4) == 0) ? 10'(1000 + $urandom % 24) : 10'($urandom % 160);
                d_row = 9'($urandom % 160);
                d_bg  = 12'($urandom);
                tick();
            end
        end
        d_cv = 1'b0; d_vld = 1'b0;
        flush();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sprite_compositor.md
SPRITE_COMPOSITOR -- requirements
Module: sprite_compositor

Interface
REQ-001 SHALL have parameter NUM_SPR, default 8: number of sprite channels, range 1..16.
REQ-002 SHALL have parameter ADDR_W, default 14: ROM address width per sprite.
REQ-003 SHALL have parameter ROM_LAT, default 1: sprite ROM read latency in clk cycles, range 1..3.
REQ-004 SHALL have parameter KEY, default 12'h428: transparent colour key.
REQ-005 SHALL have ports: clk in 1, system clock; rst in 1, reset. One clock; reset is synchronous and active-high.
REQ-006 SHALL have ports: col_addr in 10, scan column; row_addr in 9, scan row; pix_valid in 1, scan position valid; frame_start in 1, one-cycle pulse at the top of each frame.
REQ-007 SHALL have port bg_pixel in 12: background RGB444, aligned with col_addr/row_addr.
REQ-008 SHALL have ports: cfg_valid in 1; cfg_ready out 1; cfg_idx in 4; cfg_x in 10; cfg_y in 9; cfg_w in 7; cfg_h in 7; cfg_en in 1. Together these form the sprite-table write port.
REQ-009 SHALL have ports: spr_addr out NUM_SPR*ADDR_W, per-sprite ROM address; spr_data in NUM_SPR*12, per-sprite ROM data.
REQ-010 SHALL have ports: pix_out out 12, composited pixel; pix_out_valid out 1.
REQ-011 SHALL have port coll_flags out NUM_SPR: per-sprite overlap flags for the previous frame.

Function
REQ-012 SHALL hold a shadow table of {x, y, w, h, en} per sprite. A write occurs when cfg_valid and cfg_ready are both high. Writes with cfg_idx >= NUM_SPR are accepted and dropped.
REQ-013 SHALL drive cfg_ready high except during the cycle frame_start is high; a write offered in that cycle SHALL stall until the next cycle.
REQ-014 SHALL copy the shadow table to the active table on frame_start. Rendering uses only the active table (tear-free updates).
REQ-015 SHALL treat a sprite as hit when en=1, x <= col < x+w, and y <= row < y+h. Comparisons are 11/10-bit unsigned, so x+w overflow past 1023 does not wrap.
REQ-016 SHALL register spr_addr in pipeline stage 1 as (row-y)*w + (col-x) when hit, otherwise 0. The result is truncated to ADDR_W.
REQ-017 SHALL delay the hit flags, bg_pixel and pix_valid by ROM_LAT+1 cycles to align them with spr_data.
REQ-018 SHALL register the merge result in the final stage, with priority highest index > ... > index 0 > background. A sprite is opaque when hit and spr_data != KEY.
REQ-019 SHALL make total latency col/row -> pix_out exactly ROM_LAT+2 cycles. pix_out_valid is pix_valid delayed by the same amount.
REQ-020 SHALL drive pix_out to 12'h000 when the delayed pix_valid is 0.
REQ-021 SHALL detect collisions: during a frame, a per-sprite sticky bit sets when that sprite is opaque at a pixel where at least one other sprite is also opaque.
REQ-022 SHALL transfer the sticky bits to coll_flags on frame_start and clear them in the same cycle. A collision at the same cycle as frame_start counts toward the new frame.
REQ-023 SHALL, for a write to a sprite's shadow entry in the frame_start cycle+1, make it visible at the following frame only.

Reset
REQ-024 SHALL, on rst, clear shadow and active tables (all en=0), sticky bits, coll_flags, spr_addr and all pipeline registers. pix_out=0, pix_out_valid=0, cfg_ready=1 in the cycle after rst deasserts.
REQ-025 SHALL, on rst mid-frame, discard in-flight pixels; no stale pixel SHALL emerge after rst deasserts.

Structure
REQ-026 SHALL place KEY default, RGB width 12, COL_W 10 and ROW_W 9 in a shared package (sprite_pkg).
REQ-027 SHALL use one sub-module per sprite channel, named sprite_chan, containing the table entry, hit test and address stage. The top instantiates NUM_SPR of them via generate.

Verification
REQ-028 SHALL cover: rst, write sprite0 {x=10,y=20,w=8,h=8,en=1}, frame_start, scan (12,22) -> spr_addr[0]=18 one cycle later; pix_out = spr_data[0] at ROM_LAT+2 cycles.
REQ-029 SHALL cover: sprite0 and sprite1 both cover (50,50) with opaque data 12'hF00 / 12'h0F0 -> pix_out=12'h0F0; sprite1 data=12'h428 -> pix_out=12'hF00.
REQ-030 SHALL cover: write sprite0 x=100 mid-frame -> rendering keeps the old x until the next frame_start, then uses the new x.
REQ-031 SHALL cover: two opaque sprites overlapping in frame N -> coll_flags=8'b00000011 after frame N+1 start; no overlap in N+1 -> flags=0 after frame N+2 start.
REQ-032 SHALL cover: x=1020, w=8, scan col 1023 -> hit; col 0 -> no hit (no wrap).
REQ-033 SHALL cover: assert rst for 1 cycle during active scan -> pix_out_valid=0 for ROM_LAT+2 cycles after release; coll_flags=0.
